sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 30 +++
 rtl/sram_io_buf.sv | 15 +
 rtl/sram_ctrl.sv | 123 ++++++++++++
 tb/tb_sram_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: state encoding, default timing and sizing helper for the
// asynchronous SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_WAIT,
        ST_RD_DONE
    } state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_WR_SETUP = 1;
    localparam int DEF_WR_PULSE = 2;
    localparam int DEF_WR_HOLD  = 1;
    localparam int DEF_RD_WAIT  = 2;

    function automatic int max_of(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sram_io_buf.sv
// sram_io_buf: tristate pad for the SRAM data bus; drives dout when drive is
// high, otherwise releases the bus, and always returns the pad value on din.
module sram_io_buf #(
    parameter int DATA_W = 16
) (
    input  logic              drive,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] pad
);

    assign pad = drive ? dout : {DATA_W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-request asynchronous SRAM controller with programmable
// write setup/pulse/hold and read wait timing, one shared down-counter.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WR_SETUP = DEF_WR_SETUP,
    parameter int WR_PULSE = DEF_WR_PULSE,
    parameter int WR_HOLD  = DEF_WR_HOLD,
    parameter int RD_WAIT  = DEF_RD_WAIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                rdata_valid,
    output logic [ADDR_W-1:0]   ram_addr,
    inout  wire  [DATA_W-1:0]   ram_data,
    output logic                ram_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    output logic [DATA_W/8-1:0] ram_be_n
);

    localparam int BE_W  = DATA_W / 8;
    localparam int MAX_T = max_of(WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT);
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic [BE_W-1:0]    be_r;
    logic [DATA_W-1:0]  din;
    logic               drive;
    logic               accept;
    logic               last;
    logic               wr;

    // The counter holds "cycles remaining minus one" for the current phase.
    function automatic logic [CNT_W-1:0] load(input int n);
        return CNT_W'(n - 1);
    endfunction

    assign accept   = req_valid && req_ready;
    assign last     = cnt == '0;
    assign ram_addr = addr_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = last ? '0 : cnt - 1'b1;
        case (state)
            ST_IDLE: if (accept) begin
                state_nx = req_we ? ST_WR_SETUP : ST_RD_WAIT;
                cnt_nx   = req_we ? load(WR_SETUP) : load(RD_WAIT);
            end
            ST_WR_SETUP: if (last) begin
                state_nx = ST_WR_PULSE;
                cnt_nx   = load(WR_PULSE);
            end
            ST_WR_PULSE: if (last) begin
                state_nx = ST_WR_HOLD;
                cnt_nx   = load(WR_HOLD);
            end
            ST_WR_HOLD: if (last) state_nx = ST_IDLE;
            ST_RD_WAIT: if (last) state_nx = ST_RD_DONE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        wr          = state inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
        req_ready   = state == ST_IDLE;
        ram_ce_n    = state == ST_IDLE;
        ram_oe_n    = state != ST_RD_WAIT;
        ram_we_n    = state != ST_WR_PULSE;
        ram_be_n    = wr ? ~be_r : (state == ST_IDLE) ? '1 : '0;
        drive       = wr;
        done        = state == ST_WR_HOLD && last;
        rdata_valid = state == ST_RD_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= '0;
            wdata_r <= '0;
            be_r    <= '0;
            rdata   <= '0;
        end else begin
            if (accept) begin
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                be_r    <= req_be;
            end
            if (state == ST_RD_WAIT && last) rdata <= din;
        end
    end

    sram_io_buf #(.DATA_W(DATA_W)) u_io (
        .drive (drive),
        .dout  (wdata_r),
        .din   (din),
        .pad   (ram_data)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: drives two controllers (default and slow timing) against a
// behavioural SRAM and checks them with a word-level reference memory.
module tb_sram_ctrl;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [N];
    logic        req_we    [N];
    logic [17:0] req_addr  [N];
    logic [15:0] req_wdata [N];
    logic [1:0]  req_be    [N];
    logic        req_ready [N];
    logic        done      [N];
    logic        rdata_valid [N];
    logic [15:0] rdata     [N];
    logic [17:0] ram_addr  [N];
    logic        ce_n [N], oe_n [N], we_n [N];
    logic [1:0]  be_n [N];
    wire  [15:0] bus0, bus1;

    logic [15:0] init_mem [N][256];
    logic [15:0] mem      [N][256];
    logic [15:0] ref_mem  [N][256];
    logic        loaded = 1'b0;
    logic [15:0] probe;
    logic [15:0] sram_w;

    int ws [N] = '{1, 3};
    int wp [N] = '{2, 1};
    int wh [N] = '{1, 2};
    int rw [N] = '{2, 5};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.DATA_W(16), .ADDR_W(18)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .done(done[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]), .ram_addr(ram_addr[0]),
        .ram_data(bus0), .ram_ce_n(ce_n[0]), .ram_oe_n(oe_n[0]), .ram_we_n(we_n[0]), .ram_be_n(be_n[0])
    );

    sram_ctrl #(.DATA_W(16), .ADDR_W(18), .WR_SETUP(3), .WR_PULSE(1), .WR_HOLD(2), .RD_WAIT(5)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .done(done[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]), .ram_addr(ram_addr[1]),
        .ram_data(bus1), .ram_ce_n(ce_n[1]), .ram_oe_n(oe_n[1]), .ram_we_n(we_n[1]), .ram_be_n(be_n[1])
    );

    // SRAM drives on read; while deselected a probe pattern exposes any stray DUT drive.
    assign bus0 = (!ce_n[0] && !oe_n[0]) ? mem[0][ram_addr[0][7:0]] : ce_n[0] ? probe : 16'hzzzz;
    assign bus1 = (!ce_n[1] && !oe_n[1]) ? mem[1][ram_addr[1][7:0]] : ce_n[1] ? probe : 16'hzzzz;

    function automatic logic [15:0] bus_of(input int k);
        return (k == 0) ? bus0 : bus1;
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < N; k++)
                for (int i = 0; i < 256; i++)
                    mem[k][i] <= init_mem[k][i];
            loaded <= 1'b1;
        end else begin
            for (int k = 0; k < N; k++)
                if (!ce_n[k] && !we_n[k]) begin
                    sram_w = mem[k][ram_addr[k][7:0]];
                    if (!be_n[k][0]) sram_w[7:0]  = bus_of(k) >> 0;
                    if (!be_n[k][1]) sram_w[15:8] = bus_of(k) >> 8;
                    mem[k][ram_addr[k][7:0]] <= sram_w;
                end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] b);
        logic [15:0] m;
        m = {{8{b[1]}}, {8{b[0]}}};
        return (d & m) | (old & ~m);
    endfunction

    // One request on controller k; returns at the negedge of its completion pulse.
    task automatic op(input int k, input bit we, input logic [17:0] a, input logic [15:0] d,
                      input logic [1:0] b, input bit chain);
        int gap, lat, wel, oel, cel, bad;
        logic dn, rv;
        logic [15:0] exp_rd, bv;
        probe = 16'($urandom);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_be[k] = b;
        gap = 0; bad = 0;
        while (!req_ready[k] && gap < 100) begin
            @(negedge clk);
            gap++;
            if (req_ready[k] && bus_of(k) !== probe) bad++;
        end
        chk("accept_wait", 32'(gap < 100), 1);
        if (chain) chk("b2b_gap", gap, 1);
        exp_rd = ref_mem[k][a[7:0]];
        if (we) ref_mem[k][a[7:0]] = merge(exp_rd, d, b);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0; req_we[k] = 1'($urandom); req_addr[k] = 18'($urandom);
        req_wdata[k] = 16'($urandom); req_be[k] = 2'($urandom);
        lat = 0; wel = 0; oel = 0; cel = 0; dn = 0; rv = 0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(negedge clk);
            bv = bus_of(k);
            if (!we_n[k]) wel++;
            if (!oe_n[k]) oel++;
            if (!ce_n[k]) cel++;
            if (!ce_n[k] && ram_addr[k] !== a) bad++;
            if (we && !ce_n[k] && (bv !== d || be_n[k] !== ~b)) bad++;
            if (!oe_n[k] && (bv !== exp_rd || !we_n[k] || be_n[k] !== 2'b00)) bad++;
            if (done[k] || rdata_valid[k]) begin
                lat = c; dn = done[k]; rv = rdata_valid[k];
            end
        end
        chk(we ? "wr_latency" : "rd_latency", lat, we ? ws[k] + wp[k] + wh[k] : rw[k] + 1);
        chk("pulse_kind", {dn, rv}, we ? 2'b10 : 2'b01);
        chk(we ? "we_low_cycles" : "oe_low_cycles", we ? wel : oel, we ? wp[k] : rw[k]);
        chk(we ? "oe_low_in_write" : "we_low_in_read", we ? oel : wel, 0);
        chk("ce_low_cycles", cel, lat);
        chk("bus_addr_be", bad, 0);
        if (!we) chk("rdata", rdata[k], exp_rd);
    endtask

    task automatic rand_ops(input int k, input int n);
        bit ch;
        for (int i = 0; i < n; i++) begin
            ch = 1'($urandom);
            if (!ch) repeat (2) @(negedge clk);
            op(k, 1'($urandom), 18'($urandom), 16'($urandom), 2'($urandom), ch);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_done;
        for (int k = 0; k < N; k++) begin
            req_valid[k] = 0; req_we[k] = 0; req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
            for (int i = 0; i < 256; i++) begin
                init_mem[k][i] = 16'($urandom);
                ref_mem[k][i]  = init_mem[k][i];
            end
        end
        probe = 16'hA5C3;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_strobes", {ce_n[k], oe_n[k], we_n[k], be_n[k]}, 5'h1f);
            chk("rst_ready_pulses", {req_ready[k], done[k], rdata_valid[k]}, 3'b100);
            chk("rst_rdata", rdata[k], 0);
            chk("rst_addr", ram_addr[k], 0);
            chk("rst_bus_z", bus_of(k), probe);
        end
        rst = 1'b0;

        op(0, 1, 18'h00012, 16'hBEEF, 2'b11, 0);
        op(0, 0, 18'h00012, 16'h0000, 2'b00, 0);
        op(0, 1, 18'h00012, 16'h1234, 2'b01, 0);
        op(0, 0, 18'h00012, 16'h0000, 2'b00, 0);
        op(0, 1, 18'h00012, 16'h5555, 2'b00, 0);
        op(0, 0, 18'h00012, 16'h0000, 2'b00, 0);

        @(negedge clk);
        op(0, 1, 18'h00040, 16'hCAFE, 2'b10, 0);
        op(0, 0, 18'h00040, 16'h0000, 2'b00, 1);
        op(0, 1, 18'h00041, 16'h7788, 2'b11, 1);
        op(0, 0, 18'h00041, 16'h0000, 2'b00, 1);

        rand_ops(0, 25);

        // Reset during the second write-pulse cycle aborts the write.
        repeat (2) @(negedge clk);
        probe = 16'h3C96;
        chk("abort_ready", req_ready[0], 1);
        req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 18'h00077; req_wdata[0] = 16'h9E21; req_be[0] = 2'b11;
        @(posedge clk);
        #1 req_valid[0] = 0;
        ref_mem[0][8'h77] = 16'h9E21;
        repeat (3) @(negedge clk);
        chk("abort_in_pulse", {we_n[0], ce_n[0]}, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_we_n", we_n[0], 1);
        chk("abort_strobes", {ce_n[0], oe_n[0], be_n[0]}, 4'hf);
        chk("abort_bus_z", bus0, probe);
        chk("abort_ready_done", {req_ready[0], done[0], rdata_valid[0]}, 3'b100);
        rst = 1'b0;
        cnt_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done[0] || rdata_valid[0] || !ce_n[0]) cnt_done++;
        end
        chk("abort_no_activity", cnt_done, 0);
        op(0, 0, 18'h00077, 16'h0000, 2'b00, 0);

        op(1, 1, 18'h00012, 16'hBEEF, 2'b11, 0);
        op(1, 0, 18'h00012, 16'h0000, 2'b00, 1);
        op(1, 1, 18'h00012, 16'h1234, 2'b01, 1);
        op(1, 0, 18'h00012, 16'h0000, 2'b00, 1);
        rand_ops(1, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
